// File: rtl/palu_pkg.sv
// palu_pkg: opcode constants, register-index width and operand-usage helpers
// shared by the palu issue scheduler.
package palu_pkg;

    localparam int REG_W = 2;
    localparam int OPC_W = 3;
    localparam int N_REQ = 2;

    typedef enum logic [OPC_W-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        ONE  = 3'd2,
        AND  = 3'd3,
        NAND = 3'd4,
        SRL  = 3'd5,
        SRA  = 3'd6,
        CPA  = 3'd7
    } opcode_e;

    // ONE produces a constant and reads no operand.
    function automatic logic usesSrc1(logic [OPC_W-1:0] opc);
        return opc != ONE;
    endfunction

    // Shifts and CPA are unary; only the two-operand ALU ops read src2.
    function automatic logic usesSrc2(logic [OPC_W-1:0] opc);
        return (opc == ADD) || (opc == SUB) || (opc == AND) || (opc == NAND);
    endfunction

endpackage

// File: rtl/palu_sched_if.sv
// palu_sched_if: requester valid/ready handshake plus the issue bus into palu.
// master = requesters / bench side, slave = the scheduler.
interface palu_sched_if;
    import palu_pkg::*;

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0]            req_ready;
    logic [N_REQ-1:0][OPC_W-1:0] req_opcode;
    logic [N_REQ-1:0][REG_W-1:0] req_src1;
    logic [N_REQ-1:0][REG_W-1:0] req_src2;
    logic [N_REQ-1:0][REG_W-1:0] req_dest;

    logic             stall;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dest;

    modport master (
        output req_valid, req_opcode, req_src1, req_src2, req_dest,
        input  req_ready, stall, opcode, src1, src2, dest
    );

    modport slave (
        input  req_valid, req_opcode, req_src1, req_src2, req_dest,
        output req_ready, stall, opcode, src1, src2, dest
    );

endinterface

// File: rtl/palu_rr_arb.sv
// palu_rr_arb: 2-way round-robin arbiter. A lone eligible requester always
// wins; on a tie the pointer decides. The pointer moves past the winner.
module palu_rr_arb (
    input  logic [1:0] elig,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    // Pick the winner and advance the pointer past it.
    always_comb begin
        grant    = elig;
        next_ptr = ptr;
        if (elig == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
        if (grant[0]) begin
            next_ptr = 1'b1;
        end else if (grant[1]) begin
            next_ptr = 1'b0;
        end
    end

endmodule

// File: rtl/palu_sched.sv
// palu_sched: two-requester issue scheduler in front of palu. Arbitrates
// round-robin, blocks RAW hazards against the previous issue with one bubble.
// Optional build macro: PALU_SCHED_OPMASK_EN (hazard check skips operands the
// opcode does not read).
//
// state     | meaning
// ----------+--------------------------------------------------
// last_vld  | previous cycle issued an instruction
// last_dest | destination register of that instruction
// rr_ptr    | requester that wins when both are eligible
module palu_sched
    import palu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    palu_sched_if.slave      bus,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             last_vld;
    logic [REG_W-1:0] last_dest;
    logic             rr_ptr;

    logic [1:0] hazard;
    logic [1:0] elig;
    logic [1:0] grant;
    logic       next_ptr;
    logic       sel;

    // Per-requester RAW check against the last issued destination.
    always_comb begin
        hazard = '0;
        elig   = '0;
        for (int r = 0; r < N_REQ; r++) begin
            logic chk1;
            logic chk2;
`ifdef PALU_SCHED_OPMASK_EN
            chk1 = usesSrc1(bus.req_opcode[r]);
            chk2 = usesSrc2(bus.req_opcode[r]);
`else
            chk1 = 1'b1;
            chk2 = 1'b1;
`endif
            hazard[r] = last_vld &&
                        ((chk1 && (bus.req_src1[r] == last_dest)) ||
                         (chk2 && (bus.req_src2[r] == last_dest)));
            elig[r]   = bus.req_valid[r] && !hazard[r] && !hold && !reset;
        end
    end

    palu_rr_arb u_arb (
        .elig     (elig),
        .ptr      (rr_ptr),
        .grant    (grant),
        .next_ptr (next_ptr)
    );

    // Issue bus: granted requester's fields, requester 0 when stalling.
    always_comb begin
        sel           = grant[1];
        bus.req_ready = grant;
        bus.stall     = ~|grant;
        bus.opcode    = bus.req_opcode[sel];
        bus.src1      = bus.req_src1[sel];
        bus.src2      = bus.req_src2[sel];
        bus.dest      = bus.req_dest[sel];
    end

    // Scheduler state and saturating statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_vld   <= 1'b0;
            last_dest  <= '0;
            rr_ptr     <= 1'b0;
            issue_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            rr_ptr <= next_ptr;
            if (|grant) begin
                last_vld  <= 1'b1;
                last_dest <= bus.req_dest[sel];
                if (issue_cnt != {CNT_W{1'b1}}) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
            end else begin
                last_vld <= 1'b0;
                if ((|bus.req_valid) && (bubble_cnt != {CNT_W{1'b1}})) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_palu_sched.sv
// tb_palu_sched: directed scenarios plus randomized traffic, each cycle
// compared against a behavioural model of the scheduling rules.
module tb_palu_sched;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          hold;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] bubble_cnt;

    palu_sched_if bus ();

    palu_sched #(.CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .hold       (hold),
        .bus        (bus),
        .issue_cnt  (issue_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Requester-side stimulus.
    logic [1:0] v;
    logic [2:0] op [2];
    logic [1:0] a  [2];
    logic [1:0] b  [2];
    logic [1:0] d  [2];

    // Reference model state.
    int m_last_vld, m_last_dest, m_ptr, m_issue, m_bubble;
    bit m_known;

    int n_chk, n_pass;
    int last_g;
    logic       s_stall;
    logic [1:0] s_ready;
    logic [1:0] s_dest;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit reads1(input logic [2:0] opc);
`ifdef PALU_SCHED_OPMASK_EN
        return opc != 3'd2;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit reads2(input logic [2:0] opc);
`ifdef PALU_SCHED_OPMASK_EN
        return opc == 3'd0 || opc == 3'd1 || opc == 3'd3 || opc == 3'd4;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit can_issue(input int r);
        bit raw;
        raw = (m_last_vld != 0) &&
              ((reads1(op[r]) && int'(a[r]) == m_last_dest) ||
               (reads2(op[r]) && int'(b[r]) == m_last_dest));
        return v[r] && !raw && !hold && !reset;
    endfunction

    // Returns requester index to be granted, or -1 for a bubble.
    function automatic int model_grant();
        bit c0, c1;
        c0 = can_issue(0);
        c1 = can_issue(1);
        if (c0 && c1) return m_ptr;
        if (c0) return 0;
        if (c1) return 1;
        return -1;
    endfunction

    function automatic void model_update(input int g);
        if (reset) begin
            m_last_vld = 0; m_last_dest = 0; m_ptr = 0;
            m_issue = 0; m_bubble = 0; m_known = 1'b1;
        end else if (g >= 0) begin
            m_last_vld  = 1;
            m_last_dest = int'(d[g]);
            m_ptr       = 1 - g;
            if (m_issue < CMAX) m_issue++;
        end else begin
            m_last_vld = 0;
            if (v != 2'b00 && m_bubble < CMAX) m_bubble++;
        end
    endfunction

    // One clock cycle: apply inputs, check combinational issue, advance.
    task automatic cycle();
        int g;
        bus.req_valid = v;
        for (int r = 0; r < 2; r++) begin
            bus.req_opcode[r] = op[r];
            bus.req_src1[r]   = a[r];
            bus.req_src2[r]   = b[r];
            bus.req_dest[r]   = d[r];
        end
        #1;
        g = model_grant();
        chk("stall", bus.stall, (g < 0) ? 1 : 0);
        chk("req_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
            chk("opcode", bus.opcode, op[g]);
            chk("src1", bus.src1, a[g]);
            chk("src2", bus.src2, b[g]);
            chk("dest", bus.dest, d[g]);
        end
        if (m_known) begin
            chk("issue_cnt", issue_cnt, m_issue);
            chk("bubble_cnt", bubble_cnt, m_bubble);
        end
        s_stall = bus.stall;
        s_ready = bus.req_ready;
        s_dest  = bus.dest;
        last_g  = g;
        @(posedge clock);
        model_update(g);
        @(negedge clock);
    endtask

    task automatic set_req(input int r, input logic [2:0] o, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] ds);
        op[r] = o; a[r] = s1; b[r] = s2; d[r] = ds;
    endtask

    task automatic do_reset();
        reset = 1'b1; v = 2'b00;
        cycle();
        reset = 1'b0;
    endtask

    logic [1:0] seq [4];

    initial begin
        n_chk = 0; n_pass = 0; m_known = 1'b0; last_g = -1;
        m_last_vld = 0; m_last_dest = 0; m_ptr = 0; m_issue = 0; m_bubble = 0;
        hold = 1'b0; reset = 1'b1; v = 2'b00;
        for (int r = 0; r < 2; r++) set_req(r, 3'd0, 2'd0, 2'd0, 2'd0);
        @(negedge clock);

        // Reset state.
        do_reset();
        chk("rst_stall", s_stall, 1);
        chk("rst_ready", s_ready, 0);
        chk("rst_issue", issue_cnt, 0);
        chk("rst_bubble", bubble_cnt, 0);

        // ADD r1,r2->r3 then dependent SUB: one bubble then issue.
        v = 2'b01; set_req(0, 3'd0, 2'd1, 2'd2, 2'd3);
        cycle();
        chk("add_ready", s_ready, 2'b01);
        chk("add_dest", s_dest, 3);
        chk("add_stall", s_stall, 0);
        set_req(0, 3'd1, 2'd3, 2'd0, 2'd0);
        cycle();
        chk("raw_stall", s_stall, 1);
        cycle();
        chk("raw_issue", s_stall, 0);
        chk("raw_bubble", bubble_cnt, 1);

        // Both valid, independent: alternate 0,1,0,1.
        do_reset();
        v = 2'b11;
        set_req(0, 3'd0, 2'd0, 2'd0, 2'd1);
        set_req(1, 3'd3, 2'd0, 2'd0, 2'd2);
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = s_ready;
        end
        chk("alt0", seq[0], 2'b01);
        chk("alt1", seq[1], 2'b10);
        chk("alt2", seq[2], 2'b01);
        chk("alt3", seq[3], 2'b10);
        chk("alt_issue", issue_cnt, 4);

        // req0 hazarded on r2, req1 independent, pointer at 0.
        set_req(0, 3'd0, 2'd2, 2'd0, 2'd1);
        set_req(1, 3'd0, 2'd0, 2'd0, 2'd3);
        cycle();
        chk("skip_haz", s_ready, 2'b10);
        v = 2'b01;
        cycle();
        chk("haz_next", s_ready, 2'b01);

        // ONE->r1 then SRL src1=0 src2=1.
        do_reset();
        v = 2'b01; set_req(0, 3'd2, 2'd0, 2'd0, 2'd1);
        cycle();
        set_req(0, 3'd5, 2'd0, 2'd1, 2'd2);
        cycle();
        if (s_stall) cycle();
`ifdef PALU_SCHED_OPMASK_EN
        chk("opmask_bubble", bubble_cnt, 0);
`else
        chk("opmask_bubble", bubble_cnt, 1);
`endif

        // hold for 3 cycles, then reset while hold is still high.
        do_reset();
        hold = 1'b1; v = 2'b01; set_req(0, 3'd0, 2'd0, 2'd0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_stall", s_stall, 1);
        end
        chk("hold_bubble", bubble_cnt, 3);
        reset = 1'b1;
        cycle();
        reset = 1'b0; hold = 1'b0; v = 2'b00;
        chk("midrst_issue", issue_cnt, 0);
        chk("midrst_bubble", bubble_cnt, 0);

        // Randomized traffic; a requester holds its fields until accepted.
        for (int i = 0; i < 600; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (last_g == r) v[r] = 1'b0;
                if (!v[r]) begin
                    v[r] = ($urandom % 4) != 0;
                    set_req(r, 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
                end
            end
            hold  = ($urandom % 10) == 0;
            reset = ($urandom % 60) == 0;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
